// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file with busy scoreboard.
// Holds the default geometry and the hard-wired zero register index, which are also
// used by decode and writeback.
package regfile_sb_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNregs = 8;
  localparam int unsigned RegZero  = 0;

  // True when addr names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [31:0] addr);
    return addr == RegZero;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   we_i, wa_i         writeback: clears busy[wa_i]
//   iss_valid_i,
//   iss_rd_i           issue of a multicycle op: sets busy[iss_rd_i]
//   busy_o             registered busy flags, bit 0 tied 0
module rf_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned NREGS = DefNregs,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_rd_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_d, busy_q;

  // Clear first, then set: an issue and a write to the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (we_i && !is_zero_reg(32'(wa_i))) busy_d[wa_i] = 1'b0;
    if (iss_valid_i && !is_zero_reg(32'(iss_rd_i))) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// NREGS x XLEN register file, NRP read ports, one write port, with optional
// write->read bypass, optional registered read and a busy scoreboard.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   we_i, wa_i, wd_i      write port
//   ra_i                  read addresses, port p = ra_i[p*AW +: AW]
//   rd_o                  read data, port p = rd_o[p*XLEN +: XLEN]
//   rbusy_o               busy flag of the addressed register, per port
//   iss_valid_i, iss_rd_i issue of a multicycle op (marks iss_rd_i busy)
//   busy_vec_o            raw scoreboard state, bit 0 tied 0
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN     = DefXlen,
  parameter int unsigned NREGS    = DefNregs,
  parameter int unsigned NRP      = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          REG_READ = 1'b0,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [XLEN-1:0]   wd_i,
  input  logic [NRP*AW-1:0] ra_i,
  output logic [NRP*XLEN-1:0] rd_o,
  output logic [NRP-1:0]    rbusy_o,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  output logic [NREGS-1:0]  busy_vec_o
);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (we_i && !is_zero_reg(32'(wa_i))) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .we_i        (we_i),
    .wa_i        (wa_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .busy_o      (busy)
  );

  assign busy_vec_o = busy;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] v;
    logic            b;

    assign ra = ra_i[p*AW +: AW];

    always_comb begin
      v = rf_q[ra];
      b = busy[ra];
      if (BYPASS) begin
        if (we_i && wa_i == ra) v = wd_i;
        // Issue outranks write, matching the scoreboard's set-wins rule.
        if (iss_valid_i && iss_rd_i == ra) b = 1'b1;
        else if (we_i && wa_i == ra)       b = 1'b0;
      end
      // r0 must not pick up a bypassed write.
      if (is_zero_reg(32'(ra))) begin
        v = '0;
        b = 1'b0;
      end
    end

    if (REG_READ) begin : g_reg
      logic [XLEN-1:0] rd_q;
      logic            rbusy_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_q    <= '0;
          rbusy_q <= 1'b0;
        end else begin
          rd_q    <= v;
          rbusy_q <= b;
        end
      end

      assign rd_o[p*XLEN +: XLEN] = rd_q;
      assign rbusy_o[p]           = rbusy_q;
    end else begin : g_comb
      assign rd_o[p*XLEN +: XLEN] = v;
      assign rbusy_o[p]           = b;
    end
  end

endmodule
